// File: rtl/sfu_ctrl_pkg.sv
// Shared types for the SFU accumulate controller: FSM state encoding and
// the per-stage tag carried down the 2-stage control pipeline.
package sfu_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int PASS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  // One row in flight: first = pass 0 (zero base), last = final pass (ReLU out)
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] row;
    logic              first;
    logic              last;
  } stage_tag_t;

endpackage

// File: rtl/sfu_acc_ctrl_if.sv
// Control bus of the SFU accumulate controller: job start/config from the
// core controller, OFIFO pop, PMEM read/write strobes, SFU mux controls,
// output-memory write strobe, job status and the FSM state for observation.
//
// Handshake: ofifo_valid is a level meaning "at least one word queued".
// A pop happens in exactly the cycles where ofifo_rd=1, and ofifo_rd is
// only raised while ofifo_valid=1; the popped word is on psum_in one cycle
// later. start is a one-cycle pulse, accepted only while busy=0 and the
// controller is idle; n_out/n_pass are sampled only in that cycle.
interface sfu_acc_ctrl_if
  import sfu_ctrl_pkg::*;
#(
  parameter int addr_w = ADDR_W,
  parameter int pass_w = PASS_W
);
  logic              start;
  logic [addr_w-1:0] n_out;
  logic [pass_w-1:0] n_pass;
  logic              ofifo_valid;
  logic              ofifo_rd;
  logic              pmem_rd_en;
  logic [addr_w-1:0] pmem_rd_addr;
  logic              base_zero;
  logic              sfu_acc;
  logic              pmem_wr_en;
  logic [addr_w-1:0] pmem_wr_addr;
  logic              out_wr_en;
  logic [addr_w-1:0] out_addr;
  logic              busy;
  logic              done;
  fsm_state_t        state;

  modport slave (
    input  start, n_out, n_pass, ofifo_valid,
    output ofifo_rd, pmem_rd_en, pmem_rd_addr, base_zero, sfu_acc,
           pmem_wr_en, pmem_wr_addr, out_wr_en, out_addr, busy, done, state
  );

  modport master (
    output start, n_out, n_pass, ofifo_valid,
    input  ofifo_rd, pmem_rd_en, pmem_rd_addr, base_zero, sfu_acc,
           pmem_wr_en, pmem_wr_addr, out_wr_en, out_addr, busy, done, state
  );
endinterface

// File: rtl/sfu_ctrl_pipe.sv
// Two-stage tag shift register. Stage 1 lines up with the OFIFO/PMEM data
// cycle and drives the SFU mux controls; stage 2 lines up with the SFU
// sum_out and drives the PMEM and output-memory writes.
module sfu_ctrl_pipe
  import sfu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  stage_tag_t        tag_in,
  output logic              s1_valid,
  output logic              s2_valid,
  output logic              base_zero,
  output logic              sfu_acc,
  output logic              pmem_wr_en,
  output logic [ADDR_W-1:0] pmem_wr_addr,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr
);

  stage_tag_t s1, s2;

  // Advance the tags every cycle; reset empties both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= tag_in;
      s2 <= s1;
    end
  end

  // Decode stage tags into strobes; reset masks them so nothing in flight
  // reaches the memories while reset is held.
  always_comb begin
    s1_valid     = s1.valid;
    s2_valid     = s2.valid;
    base_zero    = s1.valid & s1.first & ~reset;
    sfu_acc      = ~(s1.valid & s1.last & ~reset);
    pmem_wr_en   = s2.valid & ~reset;
    pmem_wr_addr = s2.row;
    out_wr_en    = s2.valid & s2.last & ~reset;
    out_addr     = s2.row;
  end

endmodule

// File: rtl/sfu_acc_ctrl.sv
// SFU accumulate/ReLU sequencer. Walks n_out rows for each of n_pass
// accumulation passes: pop a psum, read the running sum (not on pass 0),
// write the new sum back two cycles later, and flag the ReLU result on the
// final pass. A drain between passes keeps a next-pass read from overtaking
// the previous pass's write of the same row.
module sfu_acc_ctrl
  import sfu_ctrl_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_w  = ADDR_W,
  parameter int pass_w  = PASS_W
)
(
  input  logic           clk,
  input  logic           reset,
  sfu_acc_ctrl_if.slave  io
);

  // Lane geometry belongs to the SFU datapath; this block only sequences it.
  if (psum_bw * col > 0) begin : g_lane_cfg
  end

  fsm_state_t        state, state_nxt;
  logic [addr_w-1:0] cfg_n_out, row;
  logic [pass_w-1:0] cfg_n_pass, pass;
  logic              done_q;
  logic              issue, last_row, last_pass, empty_job, pipe_empty;
  logic              s1_valid, s2_valid;
  stage_tag_t        issue_tag;

  assign issue      = (state == ST_RUN) && io.ofifo_valid && !reset;
  assign last_row   = (row == cfg_n_out - 1'b1);
  assign last_pass  = (pass == cfg_n_pass - 1'b1);
  assign empty_job  = (io.n_out == '0) || (io.n_pass == '0);
  assign pipe_empty = !s1_valid && !s2_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (io.start) state_nxt = empty_job ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && last_row) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_nxt = last_pass ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Config latch, row/pass counters and the registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_n_out  <= '0;
      cfg_n_pass <= '0;
      row        <= '0;
      pass       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if (state == ST_IDLE && io.start) begin
        cfg_n_out  <= io.n_out;
        cfg_n_pass <= io.n_pass;
        row        <= '0;
        pass       <= '0;
      end else if (issue) begin
        row <= last_row ? '0 : row + 1'b1;
      end else if (state == ST_DRAIN && pipe_empty && !last_pass) begin
        pass <= pass + 1'b1;
      end
    end
  end

  // Stage-0 tag for the row being issued this cycle.
  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = issue;
    issue_tag.row   = row;
    issue_tag.first = (pass == '0);
    issue_tag.last  = last_pass;
  end

  // Stage-0 strobes and job status.
  always_comb begin
    io.ofifo_rd     = issue;
    io.pmem_rd_en   = issue && (pass != '0);
    io.pmem_rd_addr = row;
    io.busy         = (state == ST_RUN) || (state == ST_DRAIN);
    io.done         = done_q;
    io.state        = state;
  end

  sfu_ctrl_pipe u_pipe (
    .clk          (clk),
    .reset        (reset),
    .tag_in       (issue_tag),
    .s1_valid     (s1_valid),
    .s2_valid     (s2_valid),
    .base_zero    (io.base_zero),
    .sfu_acc      (io.sfu_acc),
    .pmem_wr_en   (io.pmem_wr_en),
    .pmem_wr_addr (io.pmem_wr_addr),
    .out_wr_en    (io.out_wr_en),
    .out_addr     (io.out_addr)
  );

endmodule

// File: tb/tb_sfu_acc_ctrl.sv
// Directed bench for sfu_acc_ctrl with a one-lane OFIFO/PMEM/SFU model.
module tb_sfu_acc_ctrl;
  import sfu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sfu_acc_ctrl_if io ();

  sfu_acc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor state ----------------
  logic [6:0] exp_q[$];
  int out_val_q[$];
  int wr_addr_q[$];
  int n_ofifo, n_rd, n_wr, n_out_wr, n_done, n_bz, n_acc0, n_bad_issue;
  int first_rd_cyc, first_bz_cyc, first_out_cyc, last_out_cyc, done_cyc;
  int min_gap, pop_idx, job_n_out, start_cyc;
  bit rd_seen;
  int last_wr_cyc[128];
  int pmem_m[128];
  int ptab[8];
  int psum_d, rdata_d, sum_q;
  bit vpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Monitor + one-lane SFU model, sampled mid-cycle.
  initial begin
    int nxt_rd, nxt_sum, nxt_psum, a;
    psum_d = 0; rdata_d = -999; sum_q = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      nxt_rd = -999;
      if (io.pmem_rd_en === 1'b1) begin
        a = int'(io.pmem_rd_addr);
        n_rd++;
        rd_seen = 1'b1;
        nxt_rd = pmem_m[a];
        if (cyc - last_wr_cyc[a] < min_gap) min_gap = cyc - last_wr_cyc[a];
        if (io.ofifo_rd !== 1'b1) n_bad_issue++;
      end
      if (io.ofifo_rd === 1'b1) begin
        n_ofifo++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (io.ofifo_valid !== 1'b1) n_bad_issue++;
      end
      if (io.pmem_wr_en === 1'b1) begin
        a = int'(io.pmem_wr_addr);
        n_wr++;
        pmem_m[a] = sum_q;
        last_wr_cyc[a] = cyc;
        wr_addr_q.push_back(a);
      end
      if (io.out_wr_en === 1'b1) begin
        n_out_wr++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_val_q.push_back(sum_q > 0 ? sum_q : 0);
        if (exp_q.size() == 0) check("out_unexpected", 1, 0);
        else check("out_addr", int'(io.out_addr), int'(exp_q.pop_front()));
      end
      if (io.base_zero === 1'b1) begin
        n_bz++;
        if (first_bz_cyc < 0) first_bz_cyc = cyc;
      end
      if (io.sfu_acc === 1'b0) n_acc0++;
      if (io.done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      nxt_sum  = ((io.base_zero === 1'b1) ? 0 : rdata_d) + psum_d;
      nxt_psum = 0;
      if (io.ofifo_rd === 1'b1) begin
        nxt_psum = ptab[(job_n_out > 0 ? pop_idx / job_n_out : 0) % 8];
        pop_idx++;
      end
      psum_d  = nxt_psum;
      rdata_d = nxt_rd;
      sum_q   = nxt_sum;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    exp_q.delete(); out_val_q.delete(); wr_addr_q.delete();
    n_ofifo = 0; n_rd = 0; n_wr = 0; n_out_wr = 0; n_done = 0;
    n_bz = 0; n_acc0 = 0; n_bad_issue = 0;
    first_rd_cyc = -1; first_bz_cyc = -1; first_out_cyc = -1;
    last_out_cyc = -1; done_cyc = -1;
    min_gap = 1000; pop_idx = 0; rd_seen = 1'b0;
    for (int i = 0; i < 128; i++) last_wr_cyc[i] = -1000;
  endtask

  task automatic do_start(input int no, input int np);
    @(posedge clk); #1;
    io.start  = 1'b1;
    io.n_out  = 7'(no);
    io.n_pass = 8'(np);
    start_cyc = cyc;
    job_n_out = no;
    @(posedge clk); #1;
    io.start  = 1'b0;
    io.n_out  = 7'($urandom_range(0, 127));
    io.n_pass = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    for (int k = 0; k < budget; k++) begin
      if (toggle) io.ofifo_valid = vpat[k % 4];
      @(posedge clk); #1;
      if (n_done > 0) break;
    end
    io.ofifo_valid = 1'b1;
    if (n_done == 0) check("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int n, input int val);
    check("out_count", n_out_wr, n);
    for (int i = 0; i < out_val_q.size(); i++) check("relu_val", out_val_q[i], val);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic check_wr_seq(input int no);
    for (int i = 0; i < wr_addr_q.size(); i++) check("wr_addr", wr_addr_q[i], i % no);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    io.start = 1'b0; io.n_out = '0; io.n_pass = '0; io.ofifo_valid = 1'b1;
    for (int i = 0; i < 128; i++) pmem_m[i] = 0;
    for (int i = 0; i < 8; i++) ptab[i] = 0;
    job_n_out = 1;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(io.busy), 0);
    check("rst_done", int'(io.done), 0);
    check("rst_sfu_acc", int'(io.sfu_acc), 1);
    check("rst_base_zero", int'(io.base_zero), 0);
    check("rst_pmem_wr", int'(io.pmem_wr_en), 0);
    check("rst_out_wr", int'(io.out_wr_en), 0);
    check("rst_state", int'(io.state), int'(ST_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ofifo_rd", int'(io.ofifo_rd), 0);

    // Single pass, 4 rows, OFIFO always ready.
    clear_log();
    ptab[0] = 11;
    for (int i = 0; i < 4; i++) exp_q.push_back(7'(i));
    do_start(4, 1);
    check("t1_busy", int'(io.busy), 1);
    wait_done(200, 1'b0);
    check("t1_first_rd", first_rd_cyc, start_cyc + 1);
    check("t1_ofifo_cnt", n_ofifo, 4);
    check("t1_pmem_rd_cnt", n_rd, 0);
    check("t1_bz_cnt", n_bz, 4);
    check("t1_first_bz", first_bz_cyc, start_cyc + 2);
    check("t1_acc0_cnt", n_acc0, 4);
    check("t1_wr_cnt", n_wr, 4);
    check("t1_first_out", first_out_cyc, start_cyc + 3);
    check("t1_last_out", last_out_cyc, start_cyc + 6);
    check("t1_done_cyc", done_cyc, start_cyc + 9);
    check("t1_done_cnt", n_done, 1);
    check_wr_seq(4);
    check_outs(4, 11);
    check("t1_busy_end", int'(io.busy), 0);

    // Three passes: 5 + (-9) + 7 = 3.
    clear_log();
    ptab[0] = 5; ptab[1] = -9; ptab[2] = 7;
    for (int i = 0; i < 4; i++) exp_q.push_back(7'(i));
    do_start(4, 3);
    wait_done(300, 1'b0);
    check("t2_ofifo_cnt", n_ofifo, 12);
    check("t2_pmem_rd_cnt", n_rd, 8);
    check("t2_wr_cnt", n_wr, 12);
    check("t2_bz_cnt", n_bz, 4);
    check("t2_acc0_cnt", n_acc0, 4);
    check("t2_done_cnt", n_done, 1);
    check("t2_bad_issue", n_bad_issue, 0);
    check_wr_seq(4);
    check_outs(4, 3);

    // OFIFO valid pattern 1,0,0,1: issues at +1,+4,+5,+8.
    clear_log();
    ptab[0] = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(7'(i));
    do_start(4, 1);
    wait_done(200, 1'b1);
    check("t3_ofifo_cnt", n_ofifo, 4);
    check("t3_bad_issue", n_bad_issue, 0);
    check("t3_first_out", first_out_cyc, start_cyc + 3);
    check("t3_out_span", last_out_cyc - first_out_cyc, 7);
    check_wr_seq(4);
    check_outs(4, 2);

    // One row, four passes: each read must trail the prior write.
    clear_log();
    for (int i = 0; i < 4; i++) ptab[i] = 1;
    exp_q.push_back(7'd0);
    do_start(1, 4);
    wait_done(300, 1'b0);
    check("t4_raw_gap_ok", int'(min_gap >= 2), 1);
    check("t4_pmem_rd_cnt", n_rd, 3);
    check("t4_wr_cnt", n_wr, 4);
    check("t4_done_cnt", n_done, 1);
    check_outs(1, 4);

    // Empty jobs: done two cycles after start, no traffic.
    clear_log();
    do_start(0, 3);
    wait_done(50, 1'b0);
    check("t5_done_cyc", done_cyc, start_cyc + 2);
    check("t5_ofifo_cnt", n_ofifo, 0);
    check("t5_wr_cnt", n_wr + n_rd, 0);
    check("t5_done_cnt", n_done, 1);
    check_outs(0, 0);
    clear_log();
    do_start(5, 0);
    wait_done(50, 1'b0);
    check("t5b_done_cyc", done_cyc, start_cyc + 2);
    check("t5b_ofifo_cnt", n_ofifo, 0);

    // Start while busy is ignored.
    clear_log();
    ptab[0] = 6;
    exp_q.push_back(7'd0); exp_q.push_back(7'd1);
    do_start(2, 1);
    check("t6_busy", int'(io.busy), 1);
    io.start = 1'b1; io.n_out = 7'd5; io.n_pass = 8'd2;
    @(posedge clk); #1;
    io.start = 1'b0;
    wait_done(200, 1'b0);
    check("t6_ofifo_cnt", n_ofifo, 2);
    check("t6_wr_cnt", n_wr, 2);
    check("t6_done_cnt", n_done, 1);
    check_outs(2, 6);

    // Reset the cycle after the first pass-1 issue.
    clear_log();
    ptab[0] = 1; ptab[1] = 1;
    do_start(4, 2);
    for (int k = 0; k < 60; k++) begin
      if (rd_seen) break;
      @(posedge clk); #1;
    end
    check("t7_rd_seen", int'(rd_seen), 1);
    reset = 1'b1;
    n_wr = 0; n_out_wr = 0; n_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t7_wr_after_rst", n_wr, 0);
    check("t7_out_after_rst", n_out_wr, 0);
    check("t7_no_done", n_done, 0);
    check("t7_busy", int'(io.busy), 0);
    check("t7_sfu_acc", int'(io.sfu_acc), 1);
    check("t7_state", int'(io.state), int'(ST_IDLE));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
